// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Read side of the byte FIFO. It pops one byte at a time and sends each byte
// as a UART frame on tx: start bit, 8 data bits LSB first, an optional
// even-parity bit, then a stop bit.
//
// Ports
//   clk         in   1  sole clock, rising edge
//   rst         in   1  synchronous active-high reset; aborts any frame
//   tx_en       in   1  permits starting a new frame (sampled in IDLE only)
//   fifo_empty  in   1  FIFO empty flag
//   fifo_dout   in   8  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  1  one-cycle pop request (FETCH state only)
//   tx          out  1  registered serial line, idles high
//   busy        out  1  high in every state except IDLE
//   tx_done     out  1  one-cycle pulse in the first IDLE cycle after a stop bit
//
// Handshake with the FIFO: a pop is committed once IDLE sees tx_en=1 and
// fifo_empty=0. fifo_rd_en is then high for exactly one cycle (FETCH). The
// byte is taken from fifo_dout one cycle later (LOAD). No other pop is issued
// until the frame's stop bit has finished.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic          bit_end;
    logic          in_bit_state;
    logic          tx_d;

    assign bit_end      = (baud_cnt == LAST_CNT);
    assign in_bit_state = (state == START) || (state == DATA) ||
                          (state == PARITY) || (state == STOP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tx_en && !fifo_empty) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    next_state = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. tx_d is the value tx will carry in the cycle that
    // next_state is current, so the registered tx lines up with the state.
    always_comb begin
        fifo_rd_en = (state == FETCH);
        busy       = (state != IDLE);
        tx_d       = 1'b1;
        case (next_state)
            START:  tx_d = 1'b0;
            // At a bit boundary inside DATA the register is about to shift,
            // so the next bit to drive is shreg[1], not shreg[0].
            DATA:   tx_d = ((state == DATA) && bit_end) ? shreg[1] : shreg[0];
            PARITY: tx_d = parity_bit;
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath: baud counter, bit index, shift register, registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx      <= tx_d;
            tx_done <= (state == STOP) && bit_end;

            // The counter restarts at every bit boundary and holds 0 outside bit states.
            if (in_bit_state && !bit_end) begin
                baud_cnt <= baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
            end

            if (state == LOAD) begin
                shreg      <= fifo_dout;
                parity_bit <= ^fifo_dout;
                bit_idx    <= '0;
            end else if ((state == DATA) && bit_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule
